// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM state encodings, default widths and range-check helper
// Used by mem_responder and its RAM; the control unit shares the same state encodings.
package mem_responder_pkg;

    typedef enum logic [2:0] {
        MS_IDLE    = 3'd0,
        MS_WAIT    = 3'd1,
        MS_ACCESS  = 3'd2,
        MS_CAPTURE = 3'd3,
        MS_DONE    = 3'd4
    } mem_state_t;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    // True when a word address lies beyond a RAM of 2**depth_log2 words.
    function automatic logic out_of_range(input logic [31:0] a, input int depth_log2);
        return (a >> depth_log2) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_responder_bram.sv
// bram_sp: single-port synchronous block RAM with registered read port
module bram_sp #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
  always_ff @(posedge clk) if (en && we) mem[addr] <= d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en && !we) q <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder serving one RAM read or write per handshake
// Ports:
//   clk, rst_n          clock and async active-low reset
//   addr, data_in       word address and write data, latched when a request is accepted
//   read_en, write_en   request levels held by the initiator until done
//   data_out            last read data (zero for rejected/out-of-range reads)
//   done                one-cycle completion pulse, 3+WAIT_CYCLES cycles after the request
//   err                 only when MEM_ERR_EN is defined: flags done for rejected requests
// Optional feature macro: MEM_ERR_EN (out-of-range or both-enables requests report err).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    input  logic              write_en,
    output logic [DATA_W-1:0] data_out,
    output logic              done
`ifdef MEM_ERR_EN
    ,
    output logic              err
`endif
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    mem_state_t            r_state, w_next;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DATA_W-1:0]     r_din;
    logic [DATA_W-1:0]     w_q;
    logic [3:0]            r_cnt;
    logic                  r_wr, r_oor;
    logic                  w_req, w_accept, w_skip, w_zero_out, w_ram_en;

    assign w_req    = read_en | write_en;
    assign w_accept = (r_state == MS_IDLE) && w_req;

`ifdef MEM_ERR_EN
    logic r_both, r_err;
    // Rejected requests never touch the RAM and always report zero data.
    assign w_skip     = r_oor | r_both;
    assign w_zero_out = w_skip;
    assign err        = r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_both <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) r_both <= read_en & write_en;
            r_err <= (r_state == MS_CAPTURE) && w_skip;
        end
    end
`else
    // Write wins over a simultaneous read; out-of-range writes leave data_out alone.
    assign w_skip     = r_oor;
    assign w_zero_out = r_oor & ~r_wr;
`endif

    assign w_ram_en = (r_state == MS_ACCESS) && !w_skip;

    always_comb begin
        w_next = r_state;
        case (r_state)
            MS_IDLE:    if (w_req) w_next = (WAIT_CYCLES > 0) ? MS_WAIT : MS_ACCESS;
            MS_WAIT:    if (r_cnt == 4'd0) w_next = MS_ACCESS;
            MS_ACCESS:  w_next = MS_CAPTURE;
            MS_CAPTURE: w_next = MS_DONE;
            default:    w_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MS_IDLE;
            r_addr   <= '0;
            r_din    <= '0;
            r_wr     <= 1'b0;
            r_oor    <= 1'b0;
            r_cnt    <= 4'd0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            r_state <= w_next;
            done    <= (r_state == MS_CAPTURE);
            if (w_accept) begin
                r_addr <= addr[DEPTH_LOG2-1:0];
                r_din  <= data_in;
                r_wr   <= write_en;
                r_oor  <= out_of_range(32'(addr), DEPTH_LOG2);
                r_cnt  <= WAIT_LOAD;
            end else if (r_state == MS_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == MS_CAPTURE) begin
                if (w_zero_out) data_out <= '0;
                else if (!r_wr) data_out <= w_q;
            end
        end
    end

    bram_sp #(
        .AW        (DEPTH_LOG2),
        .DW        (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_ram_en),
        .we    (r_wr),
        .addr  (r_addr),
        .d     (r_din),
        .q     (w_q)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table-driven bench for mem_responder (WAIT_CYCLES 0 and 2)
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr, data_in, data_out;
    logic        read_en, write_en, done, err;
    logic [15:0] addr2, din2, dout2;
    logic        rd2, wr2, done2, err2;

    int errors = 0;
    int checks = 0;

`ifdef MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
    assign err  = 1'b0;
    assign err2 = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .read_en(read_en), .write_en(write_en), .data_out(data_out), .done(done)
`ifdef MEM_ERR_EN
        , .err(err)
`endif
    );

    mem_responder #(.WAIT_CYCLES(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .addr(addr2), .data_in(din2),
        .read_en(rd2), .write_en(wr2), .data_out(dout2), .done(done2)
`ifdef MEM_ERR_EN
        , .err(err2)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] dout;
        logic [15:0] dout_e;
        logic        err_e;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w, input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        if (w) begin
            rd2 = rd; wr2 = wr; addr2 = a; din2 = d;
        end else begin
            read_en = rd; write_en = wr; addr = a; data_in = d;
        end
    endtask

    // One handshake: request at a negedge, address/data scrambled after acceptance,
    // optional early drop, enables dropped when done is seen. cyc = done cycle or -1.
    task automatic txn(input bit w, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input int drop_at, output int cyc,
                       output logic after, output logic [15:0] dv, output logic ev);
        @(negedge clk);
        drive(w, rd, wr, a, d);
        cyc = -1;
        dv  = 'x;
        ev  = 1'bx;
        for (int k = 1; k <= 12 && cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) drive(w, rd, wr, ~a, ~d);
            if (k == drop_at) drive(w, 1'b0, 1'b0, ~a, ~d);
            if (w ? done2 : done) begin
                cyc = k;
                dv  = w ? dout2 : data_out;
                ev  = w ? err2 : err;
                drive(w, 1'b0, 1'b0, ~a, ~d);
            end
        end
        @(negedge clk);
        after = w ? done2 : done;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc, n, first;
        logic        aft, ev;
        logic [15:0] dv;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        vt[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 16'h1000, 16'h1234, 16'hBEEF, 16'h0000, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 16'h1111, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 16'h0FFF, 16'h5A5A, 16'h1111, 16'h1111, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 16'h0FFF, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 16'h0020, 16'h00AA, 16'h0000, 16'h0000, 1'b1};
        vt[10] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h00AA, 16'h0000, 1'b0};
        vt[11] = '{1'b0, 1'b1, 16'h0020, 16'h7777, 16'h00AA, 16'h0000, 1'b0};
        vt[12] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h7777, 16'h7777, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset done", 32'(done), 32'd0);
        chk("reset data_out", 32'(data_out), 32'd0);
        if (ERR_EN) chk("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            txn(0, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 0, cyc, aft, dv, ev);
            chk($sformatf("vec%0d done cycle", i), 32'(cyc), 32'd3);
            chk($sformatf("vec%0d done width", i), 32'(aft), 32'd0);
            chk($sformatf("vec%0d data_out", i), 32'(dv), 32'(ERR_EN ? vt[i].dout_e : vt[i].dout));
            if (ERR_EN) chk($sformatf("vec%0d err", i), 32'(ev), 32'(vt[i].err_e));
        end

        // Enable dropped in cycle 1 still completes.
        txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, cyc, aft, dv, ev);
        chk("early drop done cycle", 32'(cyc), 32'd3);
        chk("early drop data_out", 32'(dv), 32'hBEEF);

        // Enable held through the done cycle must not retrigger.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        n = 0;
        first = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == first + 1 && first > 0) drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            if (done) begin
                n++;
                if (first < 0) first = k;
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("hold first done cycle", 32'(first), 32'd3);
        chk("hold done count", 32'(n), 32'd1);
        chk("hold data_out", 32'(data_out), 32'h1111);

        // Async reset mid-read clears outputs immediately.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0FFF, 16'h0000);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-read reset done", 32'(done), 32'd0);
        chk("mid-read reset data_out", 32'(data_out), 32'd0);
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("mid-read reset no done", 32'(n), 32'd0);
        txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, cyc, aft, dv, ev);
        chk("post-reset done cycle", 32'(cyc), 32'd3);
        chk("post-reset data_out", 32'(dv), 32'hBEEF);

        // Reset before the ACCESS edge of a write leaves the RAM untouched.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 16'h0010, 16'h9999);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("write reset no done", 32'(n), 32'd0);
        txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, cyc, aft, dv, ev);
        chk("write reset location", 32'(dv), 32'hBEEF);

        // Wait-state instance: done on cycle 5, one cycle wide.
        txn(1, 1'b0, 1'b1, 16'h0000, 16'h4242, 0, cyc, aft, dv, ev);
        chk("wait write done cycle", 32'(cyc), 32'd5);
        chk("wait write done width", 32'(aft), 32'd0);
        chk("wait write data_out", 32'(dv), 32'd0);
        txn(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, cyc, aft, dv, ev);
        chk("wait read done cycle", 32'(cyc), 32'd5);
        chk("wait read done width", 32'(aft), 32'd0);
        chk("wait read data_out", 32'(dv), 32'h4242);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
